// File: rtl/camara_pkg.sv
// Shared timing defaults, line/frame length derivation, FSM states and RGB332 pixel layout
// for the frame buffer reader and its raster timing generator.
package camara_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned ADR_W_DEF    = 24;

  // Total length of a line (or frame, in lines) from its four intervals.
  function automatic int unsigned span_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // RGB332: red in [7:5], green in [4:2], blue in [1:0].
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Per-pixel control bits that travel down the pipeline with the data.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  // Colour of vertical bar k: each index bit switches one colour channel fully on.
  function automatic rgb332_t bar_colour(input logic [2:0] k);
    rgb332_t c;
    c.r = k[2] ? 3'd7 : 3'd0;
    c.g = k[1] ? 3'd7 : 3'd0;
    c.b = k[0] ? 2'd3 : 2'd0;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster position counters with active-area and sync-interval decode; counters sit at 0
// whenever run is low.
module vga_timing import camara_pkg::*; #(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HC_W    = $clog2(H_TOTAL),
  localparam int unsigned VC_W    = $clog2(V_TOTAL)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run,
  output logic [HC_W-1:0] hcnt,
  output logic [VC_W-1:0] vcnt,
  output logic            active,
  output logic            hs,
  output logic            vs
);

  always_ff @(posedge clk_i) begin
    if (!rst_i || !run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HC_W'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VC_W'(V_TOTAL - 1)) ? '0 : vcnt + VC_W'(1);
    end else begin
      hcnt <= hcnt + HC_W'(1);
    end
  end

  assign active = (hcnt < HC_W'(H_ACTIVE)) && (vcnt < VC_W'(V_ACTIVE));
  assign hs     = (hcnt >= HC_W'(H_ACTIVE + H_FP)) && (hcnt < HC_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs     = (vcnt >= VC_W'(V_ACTIVE + V_FP)) && (vcnt < VC_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/frame_buffer_reader.sv
// VGA scan-out from an RGB332 frame buffer with a 3-stage address/data/output pipeline.
// Optional vertical colour-bar source under TEST_PATTERN_EN.
module frame_buffer_reader import camara_pkg::*; #(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned ADR_W    = ADR_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  output logic [ADR_W-1:0] rd_adr_o,
  input  logic [7:0]       rd_dat_i,
  output logic             vga_hs_o,
  output logic             vga_vs_o,
  output logic             vga_de_o,
  output logic [2:0]       vga_r_o,
  output logic [2:0]       vga_g_o,
  output logic [1:0]       vga_b_o,
  output logic             frame_start_o,
`ifdef TEST_PATTERN_EN
  input  logic             test_pattern_i,
`endif
  output logic             busy_o
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned PA_W    = $clog2(H_ACTIVE * V_ACTIVE + 1);

  state_t          state;
  logic            running;
  logic [HC_W-1:0] hcnt;
  logic [VC_W-1:0] vcnt;
  logic            t_active;
  logic            t_hs;
  logic            t_vs;
  logic            frame_end;
  logic [PA_W-1:0] pix_adr;
  logic [PA_W-1:0] adr_cur;
  ctl_t            s0_ctl;
  ctl_t            s1_ctl;
  ctl_t            s2_ctl;
  rgb332_t         s2_pix;

  assign running = (state != ST_IDLE);

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run    (running),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .active (t_active),
    .hs     (t_hs),
    .vs     (t_vs)
  );

  assign frame_end = (hcnt == HC_W'(H_TOTAL - 1)) && (vcnt == VC_W'(V_TOTAL - 1));

  // Scan-out control; DRAIN only leaves on the last pixel clock of a frame.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable_i) begin
            state  <= ST_RUN;
            busy_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable_i) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable_i) begin
            state <= ST_RUN;
          end else if (frame_end) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // S0: control bits for the current raster position, all inactive while idle.
  assign s0_ctl.de = running && t_active;
  assign s0_ctl.hs = running && t_hs;
  assign s0_ctl.vs = running && t_vs;
  assign s0_ctl.fs = (state == ST_RUN) && (hcnt == '0) && (vcnt == '0);

  // Running pixel index; equals vcnt*H_ACTIVE+hcnt on every active position.
  assign adr_cur = ((hcnt == '0) && (vcnt == '0)) ? '0 : pix_adr;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pix_adr <= '0;
    end else if (s0_ctl.de) begin
      pix_adr <= adr_cur + PA_W'(1);
    end else begin
      pix_adr <= adr_cur;
    end
  end

  // S1 address register and the control delay line through S2.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_adr_o <= '0;
      s1_ctl   <= '0;
      s2_ctl   <= '0;
    end else begin
      if (s0_ctl.de) rd_adr_o <= ADR_W'(adr_cur);
      s1_ctl <= s0_ctl;
      s2_ctl <= s1_ctl;
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [BC_W-1:0] bar_cnt;
  logic [2:0]      s0_bar;
  logic [2:0]      s1_bar;
  logic [2:0]      s2_bar;

  // Bar index tracks hcnt across the active line and is carried alongside the address.
  always_ff @(posedge clk_i) begin
    if (!rst_i || !s0_ctl.de) begin
      bar_cnt <= '0;
      s0_bar  <= '0;
    end else if (bar_cnt == BC_W'(BAR_W - 1)) begin
      bar_cnt <= '0;
      s0_bar  <= s0_bar + 3'd1;
    end else begin
      bar_cnt <= bar_cnt + BC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_bar <= '0;
      s2_bar <= '0;
    end else begin
      s1_bar <= s0_bar;
      s2_bar <= s1_bar;
    end
  end

  assign s2_pix = test_pattern_i ? bar_colour(s2_bar) : rgb332_t'(rd_dat_i);
`else
  assign s2_pix = rgb332_t'(rd_dat_i);
`endif

  // S3 output register: syncs are active low, colours blanked outside de.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vga_hs_o      <= 1'b1;
      vga_vs_o      <= 1'b1;
      vga_de_o      <= 1'b0;
      vga_r_o       <= '0;
      vga_g_o       <= '0;
      vga_b_o       <= '0;
      frame_start_o <= 1'b0;
    end else begin
      vga_hs_o      <= ~s2_ctl.hs;
      vga_vs_o      <= ~s2_ctl.vs;
      vga_de_o      <= s2_ctl.de;
      vga_r_o       <= s2_ctl.de ? s2_pix.r : 3'd0;
      vga_g_o       <= s2_ctl.de ? s2_pix.g : 3'd0;
      vga_b_o       <= s2_ctl.de ? s2_pix.b : 2'd0;
      frame_start_o <= s2_ctl.fs;
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader on a reduced raster (80x55 clocks, 64x48 visible).
// Colour-bar checks are compiled in with TEST_PATTERN_EN.
`timescale 1ns/1ps
module tb_frame_buffer_reader;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 3;
  localparam int ADR_W = 24;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             enable_i = 1'b0;
  logic [ADR_W-1:0] rd_adr_o;
  logic [7:0]       rd_dat_i;
  logic             vga_hs_o, vga_vs_o, vga_de_o, frame_start_o, busy_o;
  logic [2:0]       vga_r_o, vga_g_o;
  logic [1:0]       vga_b_o;
  logic [7:0]       scramble = 8'h00;
`ifdef TEST_PATTERN_EN
  logic             test_pattern_i = 1'b0;
`endif

  frame_buffer_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .ADR_W(ADR_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .rd_adr_o      (rd_adr_o),
    .rd_dat_i      (rd_dat_i),
    .vga_hs_o      (vga_hs_o),
    .vga_vs_o      (vga_vs_o),
    .vga_de_o      (vga_de_o),
    .vga_r_o       (vga_r_o),
    .vga_g_o       (vga_g_o),
    .vga_b_o       (vga_b_o),
    .frame_start_o (frame_start_o),
`ifdef TEST_PATTERN_EN
    .test_pattern_i(test_pattern_i),
`endif
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous RAM returning the low address byte, one clock after the address.
  always @(posedge clk_i) rd_dat_i <= rd_adr_o[7:0] ^ scramble;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;
  int n = -1;
  bit mon_en = 1'b0;
  int s_err = 0, a_err = 0, de_cnt = 0, fs_cnt = 0, max_adr = 0;
  int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1, vs_fall1 = -1, vs_rise1 = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  typedef struct {
    int x; int y;
    int de; int hs; int vs; int r; int g; int b;
  } vec_t;
  vec_t vec[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pins();
    return {21'd0, vga_de_o, vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o};
  endfunction

  // Closed-form expectation of every pin for the first frame after enable.
  task automatic monitor();
    int p, h, v, q, qh, qv, a;
    logic e_de, e_hs, e_vs, e_fs;
    logic [7:0] e_pix;
    h = 0; v = 0;
    p = n - LAT;
    if (p < 0) begin
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    end else begin
      h = (p % FRAME) % HT; v = (p % FRAME) / HT;
      e_de = (h < HA) && (v < VA);
      e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      e_fs = (p == 0);
    end
    e_pix = e_de ? 8'(v * HA + h) : 8'h00;
    if ({vga_de_o, vga_hs_o, vga_vs_o, frame_start_o} !== {e_de, e_hs, e_vs, e_fs} ||
        {vga_r_o, vga_g_o, vga_b_o} !== e_pix) s_err++;
    q = n - 1;
    if (q < 0) a = 0;
    else begin
      qh = (q % FRAME) % HT; qv = (q % FRAME) / HT;
      if (qv >= VA) a = HA * VA - 1;
      else if (qh >= HA) a = qv * HA + HA - 1;
      else a = qv * HA + qh;
    end
    if (rd_adr_o !== ADR_W'(a)) a_err++;
    if (int'(rd_adr_o) > max_adr) max_adr = int'(rd_adr_o);
    if (vga_de_o === 1'b1) de_cnt++;
    if (frame_start_o === 1'b1) fs_cnt++;
    if (prev_hs === 1'b1 && vga_hs_o === 1'b0) begin
      if (hs_fall1 < 0) hs_fall1 = n; else if (hs_fall2 < 0) hs_fall2 = n;
    end
    if (prev_hs === 1'b0 && vga_hs_o === 1'b1 && hs_rise1 < 0) hs_rise1 = n;
    if (prev_vs === 1'b1 && vga_vs_o === 1'b0 && vs_fall1 < 0) vs_fall1 = n;
    if (prev_vs === 1'b0 && vga_vs_o === 1'b1 && vs_rise1 < 0) vs_rise1 = n;
    prev_hs = vga_hs_o;
    prev_vs = vga_vs_o;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    n++;
    if (mon_en) monitor();
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  initial begin
    int fs_late;
    int tp_err;
    // Hand-computed probes: RAM byte is (y*64+x)[7:0], split as RGB332.
    vec[0]  = '{5, 0,  1, 1, 1, 0, 1, 1};
    vec[1]  = '{63, 0, 1, 1, 1, 1, 7, 3};
    vec[2]  = '{64, 0, 0, 1, 1, 0, 0, 0};
    vec[3]  = '{67, 0, 0, 1, 1, 0, 0, 0};
    vec[4]  = '{68, 0, 0, 0, 1, 0, 0, 0};
    vec[5]  = '{75, 0, 0, 0, 1, 0, 0, 0};
    vec[6]  = '{76, 0, 0, 1, 1, 0, 0, 0};
    vec[7]  = '{10, 1, 1, 1, 1, 2, 2, 2};
    vec[8]  = '{40, 20, 1, 1, 1, 1, 2, 0};
    vec[9]  = '{63, 47, 1, 1, 1, 7, 7, 3};
    vec[10] = '{0, 48, 0, 1, 1, 0, 0, 0};
    vec[11] = '{0, 50, 0, 1, 0, 0, 0, 0};
    vec[12] = '{79, 51, 0, 1, 0, 0, 0, 0};
    vec[13] = '{0, 52, 0, 1, 1, 0, 0, 0};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_adr", 32'(rd_adr_o), 32'd0);
    check("rst_pins", pins(), {21'd0, 3'b011, 8'h00});
    check("rst_fs", 32'(frame_start_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

    rst_i = 1'b1;
    step();
    check("idle_busy", 32'(busy_o), 32'd0);

    // First frame: enable, fixed latency, address sequence, then the probe table.
    enable_i = 1'b1;
    n = -1;
    mon_en = 1'b1;
    step();
    check("busy_run", 32'(busy_o), 32'd1);
    step();
    check("adr_seq0", 32'(rd_adr_o), 32'd0);
    step();
    check("adr_seq1", 32'(rd_adr_o), 32'd1);
    check("de_before_lat", 32'(vga_de_o), 32'd0);
    step();
    check("adr_seq2", 32'(rd_adr_o), 32'd2);
    check("first_de", 32'(vga_de_o), 32'd1);
    check("first_fs", 32'(frame_start_o), 32'd1);
    step();
    check("fs_one_pulse", 32'(frame_start_o), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_to(vec[i].y * HT + vec[i].x + LAT);
      check($sformatf("pix(%0d,%0d)", vec[i].x, vec[i].y), pins(),
            {21'd0, 1'(vec[i].de), 1'(vec[i].hs), 1'(vec[i].vs),
             3'(vec[i].r), 3'(vec[i].g), 2'(vec[i].b)});
    end

    run_to(FRAME + LAT - 1);
    mon_en = 1'b0;
    check("stream_pins_errs", 32'(s_err), 32'd0);
    check("stream_adr_errs", 32'(a_err), 32'd0);
    check("de_count", 32'(de_cnt), 32'(HA * VA));
    check("fs_count", 32'(fs_cnt), 32'd1);
    check("hs_start", 32'(hs_fall1), 32'(HA + HF + LAT));
    check("hs_period", 32'(hs_fall2 - hs_fall1), 32'(HT));
    check("hs_width", 32'(hs_rise1 - hs_fall1), 32'(HS));
    check("vs_start", 32'(vs_fall1), 32'((VA + VF) * HT + LAT));
    check("vs_width", 32'(vs_rise1 - vs_fall1), 32'(VS * HT));
    check("last_adr", 32'(max_adr), 32'(HA * VA - 1));
    step();
    check("fs_frame2", 32'(frame_start_o), 32'd1);

    // Drop enable mid-frame: frame completes, then idle.
    run_to(FRAME + 10 * HT);
    enable_i = 1'b0;
    step();
    check("drain_busy", 32'(busy_o), 32'd1);
    run_to(FRAME + 47 * HT + 63 + LAT);
    check("drain_last_de", 32'(vga_de_o), 32'd1);
    run_to(2 * FRAME - 1);
    check("drain_busy_end", 32'(busy_o), 32'd1);
    step();
    check("idle_at_frame_end", 32'(busy_o), 32'd0);
    fs_late = 0;
    repeat (8) begin
      step();
      if (frame_start_o !== 1'b0) fs_late++;
    end
    check("idle_no_fs", 32'(fs_late), 32'd0);
    check("idle_pins", pins(), {21'd0, 3'b011, 8'h00});
    check("idle_adr_hold", 32'(rd_adr_o), 32'(HA * VA - 1));

    // Drain then re-enable before frame end: scan-out keeps running.
    enable_i = 1'b1;
    n = -1;
    step();
    run_to(10 * HT);
    enable_i = 1'b0;
    run_to(20 * HT);
    check("redrain_busy", 32'(busy_o), 32'd1);
    enable_i = 1'b1;
    run_to(FRAME);
    check("reenable_busy", 32'(busy_o), 32'd1);
    run_to(FRAME + LAT);
    check("reenable_fs", 32'(frame_start_o), 32'd1);

    // Reset in the middle of a line, then restart from address 0.
    run_to(FRAME + 24 * HT + 30);
    rst_i = 1'b0;
    step();
    check("midrst_adr", 32'(rd_adr_o), 32'd0);
    check("midrst_pins", pins(), {21'd0, 3'b011, 8'h00});
    check("midrst_fs_busy", {30'd0, frame_start_o, busy_o}, 32'd0);
    step();
    rst_i = 1'b1;
    n = -1;
    step();
    check("restart_busy", 32'(busy_o), 32'd1);
    run_to(LAT);
    check("restart_adr", 32'(rd_adr_o), 32'd2);
    check("restart_fs_de", {30'd0, frame_start_o, vga_de_o}, 32'd3);
    run_to(5 + LAT);
    check("restart_pix5", pins(), {21'd0, 3'b111, 3'd0, 3'd1, 2'd1});

`ifdef TEST_PATTERN_EN
    // Bars on line 1, RAM data scrambled so it cannot leak through.
    test_pattern_i = 1'b1;
    scramble = 8'hA5;
    tp_err = 0;
    for (int x = 0; x < 8; x++) begin
      run_to(HT + x + LAT);
      if ({vga_r_o, vga_g_o, vga_b_o} !== 8'h00) tp_err++;
    end
    check("tp_bar0", 32'(tp_err), 32'd0);
    run_to(HT + 8 + LAT);
    check("tp_bar1", 32'({vga_r_o, vga_g_o, vga_b_o}), 32'h03);
    tp_err = 0;
    for (int x = 56; x < 64; x++) begin
      run_to(HT + x + LAT);
      if ({vga_r_o, vga_g_o, vga_b_o} !== 8'hFF) tp_err++;
    end
    check("tp_bar7", 32'(tp_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
